// File: rtl/regfile_seq.sv
// Command sequencer for the RNBIP-2 8x8 register file: expands instruction bytes
// into enab/mux_sel/reg_sel/seg command cycles. Optional macro: RFSEQ_ILLEGAL_TRAP_EN.
module regfile_seq #(
    parameter int IMM_WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ir_valid,
    input  logic [7:0] ir,
    output logic       ir_ready,
    output logic [1:0] enab,
    output logic [2:0] mux_sel,
    output logic [2:0] reg_sel,
    output logic [2:0] seg,
    output logic       or2_load,
    output logic [7:0] or2_data,
    output logic [2:0] alu_fn,
    output logic       busy,
    output logic       err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_IMM,
        S_LOAD,
        S_WRITE,
        S_READ,
        S_ALU_WAIT,
        S_ALU_WB,
`ifdef RFSEQ_ILLEGAL_TRAP_EN
        S_TRAP,
`endif
        S_CLEAR
    } state_t;

    localparam logic [1:0] ENAB_CLR  = 2'b00;
    localparam logic [1:0] ENAB_WR   = 2'b01;
    localparam logic [1:0] ENAB_HOLD = 2'b10;
    localparam logic [1:0] ENAB_RD   = 2'b11;

    localparam logic [2:0] SRC_R0  = 3'b000;
    localparam logic [2:0] SRC_RN  = 3'b001;
    localparam logic [2:0] SRC_OR2 = 3'b010;
    localparam logic [2:0] SRC_ALU = 3'b011;

    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_ALU = 2'b10;
    localparam logic [1:0] OP_SYS = 2'b11;

    // Counter holds 0..IMM_WAIT_MAX-1; the abort fires on the last of those cycles.
    localparam int CW = (IMM_WAIT_MAX > 1) ? $clog2(IMM_WAIT_MAX) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(IMM_WAIT_MAX - 1);

    state_t          state_q;
    logic [2:0]      rd_q;
    logic [CW-1:0]   wait_q;
    logic [1:0]      enab_q;
    logic [2:0]      mux_sel_q;
    logic [2:0]      reg_sel_q;
    logic [2:0]      seg_q;
    logic            or2_load_q;
    logic [7:0]      or2_data_q;
    logic [2:0]      alu_fn_q;
    logic            err_q;
    logic            xfer;

    assign ir_ready = (state_q == S_IDLE) || (state_q == S_IMM);
    assign xfer     = ir_valid && ir_ready;
    assign busy     = (state_q != S_IDLE);

    assign enab     = enab_q;
    assign mux_sel  = mux_sel_q;
    assign reg_sel  = reg_sel_q;
    assign seg      = seg_q;
    assign or2_load = or2_load_q;
    assign or2_data = or2_data_q;
    assign alu_fn   = alu_fn_q;
    assign err      = err_q;

    // Command registers are loaded with the values belonging to the state being
    // entered, so they line up cycle-for-cycle with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_q       <= 3'b000;
            wait_q     <= '0;
            enab_q     <= ENAB_HOLD;
            mux_sel_q  <= 3'b000;
            reg_sel_q  <= 3'b000;
            seg_q      <= 3'b000;
            or2_load_q <= 1'b0;
            or2_data_q <= 8'h00;
            alu_fn_q   <= 3'b000;
            err_q      <= 1'b0;
        end else begin
            enab_q     <= ENAB_HOLD;
            mux_sel_q  <= 3'b000;
            reg_sel_q  <= 3'b000;
            seg_q      <= 3'b000;
            or2_load_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (xfer) begin
                        rd_q <= ir[5:3];
                        unique case (ir[7:6])
                            OP_MOV: begin
                                state_q   <= S_WRITE;
                                enab_q    <= ENAB_WR;
                                mux_sel_q <= (ir[2:0] == 3'b000) ? SRC_R0 : SRC_RN;
                                reg_sel_q <= ir[2:0];
                                seg_q     <= ir[5:3];
                            end
                            OP_MVI: begin
                                state_q <= S_IMM;
                                wait_q  <= '0;
                            end
                            OP_ALU: begin
                                state_q  <= S_READ;
                                alu_fn_q <= ir[5:3];
                                enab_q   <= ENAB_RD;
                                seg_q    <= ir[2:0];
                            end
                            OP_SYS: begin
                                if (ir[5:0] == 6'd0) begin
                                    state_q <= S_CLEAR;
                                    enab_q  <= ENAB_CLR;
                                end
`ifdef RFSEQ_ILLEGAL_TRAP_EN
                                else if (ir[5:0] != 6'd1) begin
                                    state_q <= S_TRAP;
                                    err_q   <= 1'b1;
                                end
`endif
                            end
                        endcase
                    end
                end
                S_IMM: begin
                    if (xfer) begin
                        or2_data_q <= ir;
                        or2_load_q <= 1'b1;
                        state_q    <= S_LOAD;
                    end else if ((IMM_WAIT_MAX > 0) && (wait_q == WAIT_LAST)) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        wait_q <= wait_q + CW'(1);
                    end
                end
                S_LOAD: begin
                    state_q   <= S_WRITE;
                    enab_q    <= ENAB_WR;
                    mux_sel_q <= SRC_OR2;
                    seg_q     <= rd_q;
                end
                S_READ: begin
                    state_q <= S_ALU_WAIT;
                end
                S_ALU_WAIT: begin
                    state_q   <= S_ALU_WB;
                    enab_q    <= ENAB_WR;
                    mux_sel_q <= SRC_ALU;
                end
`ifdef RFSEQ_ILLEGAL_TRAP_EN
                S_TRAP: begin
                    state_q <= S_TRAP;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_seq.sv
// Scoreboard bench for regfile_seq: stimulus pushes expected per-cycle command
// vectors, a negedge monitor pops one for every busy cycle and compares.
module tb_regfile_seq;

    logic       clk;
    logic       rst;
    logic       ir_valid;
    logic [7:0] ir;
    logic       ir_ready;
    logic [1:0] enab;
    logic [2:0] mux_sel;
    logic [2:0] reg_sel;
    logic [2:0] seg;
    logic       or2_load;
    logic [7:0] or2_data;
    logic [2:0] alu_fn;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b1;

    typedef struct packed {
        logic [1:0] enab;
        logic [2:0] mux;
        logic [2:0] rsel;
        logic [2:0] seg;
        logic       load;
        logic [7:0] data;
        logic [2:0] fn;
        logic       rdy;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    regfile_seq #(.IMM_WAIT_MAX(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .ir_valid (ir_valid),
        .ir       (ir),
        .ir_ready (ir_ready),
        .enab     (enab),
        .mux_sel  (mux_sel),
        .reg_sel  (reg_sel),
        .seg      (seg),
        .or2_load (or2_load),
        .or2_data (or2_data),
        .alu_fn   (alu_fn),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] e, input logic [2:0] m, input logic [2:0] r,
                                input logic [2:0] s, input logic l, input logic [7:0] d,
                                input logic [2:0] f, input logic rd);
        exp_t x;
        x.enab = e; x.mux = m; x.rsel = r; x.seg = s;
        x.load = l; x.data = d; x.fn = f; x.rdy = rd;
        return x;
    endfunction

    function automatic exp_t actual();
        return mk(enab, mux_sel, reg_sel, seg, or2_load, or2_data, alu_fn, ir_ready);
    endfunction

    task automatic push(input string nm, input exp_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic issue(input logic [7:0] b, output int waited);
        @(negedge clk);
        ir       = b;
        ir_valid = 1'b1;
        waited   = 0;
        while (!ir_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!ir_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: byte %h never accepted", b);
        end
        @(posedge clk);
        #1 ir_valid = 1'b0;
        $display("issue byte=%h waited=%0d", b, waited);
    endtask

    task automatic expect_idle_after(input int n, input string nm);
        repeat (n + 1) @(negedge clk);
        chk({nm, "_enab"},  32'(enab), 32'(2'b10));
        chk({nm, "_busy"},  32'(busy), 32'd0);
        chk({nm, "_ready"}, 32'(ir_ready), 32'd1);
    endtask

    always @(negedge clk) begin
        if (mon_en && busy) begin
            exp_t  e;
            exp_t  a;
            string nm;
            a = actual();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_busy: got %h expected no busy cycle", a);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", nm, a, e);
                end else begin
                    $display("cmd %s enab=%b mux=%b reg=%b seg=%b load=%b data=%h fn=%b",
                             nm, enab, mux_sel, reg_sel, seg, or2_load, or2_data, alu_fn);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t rst_v;
        exp_t imm_v;
        int   w0;
        int   w1;
        rst_v = mk(2'b10, 3'b000, 3'b000, 3'b000, 1'b0, 8'h00, 3'b000, 1'b1);

        rst = 1'b1; ir_valid = 1'b0; ir = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 32'(actual()), 32'(rst_v));
        chk("reset_busy",    32'(busy), 32'd0);
        chk("reset_err",     32'(err),  32'd0);

        // MOV R3,R5
        push("mov_r3_r5", mk(2'b01, 3'b001, 3'b101, 3'b011, 1'b0, 8'h00, 3'b000, 1'b0));
        issue(8'h1D, w0);
        expect_idle_after(1, "mov_idle");

        // MOV R4,R4 still writes
        push("mov_r4_r4", mk(2'b01, 3'b001, 3'b100, 3'b100, 1'b0, 8'h00, 3'b000, 1'b0));
        issue(8'h24, w0);
        expect_idle_after(1, "movself_idle");

        // MVI R2, A5 with three idle cycles between bytes
        imm_v = mk(2'b10, 3'b000, 3'b000, 3'b000, 1'b0, 8'h00, 3'b000, 1'b1);
        for (int i = 0; i < 4; i++) push("mvi_imm_wait", imm_v);
        push("mvi_load",  mk(2'b10, 3'b000, 3'b000, 3'b000, 1'b1, 8'hA5, 3'b000, 1'b0));
        push("mvi_write", mk(2'b01, 3'b010, 3'b000, 3'b010, 1'b0, 8'hA5, 3'b000, 1'b0));
        issue(8'h50, w0);
        repeat (3) @(negedge clk);
        issue(8'hA5, w0);
        expect_idle_after(2, "mvi_idle");

        // ALU fn=3 on R6
        push("alu_read", mk(2'b11, 3'b000, 3'b000, 3'b110, 1'b0, 8'hA5, 3'b011, 1'b0));
        push("alu_wait", mk(2'b10, 3'b000, 3'b000, 3'b000, 1'b0, 8'hA5, 3'b011, 1'b0));
        push("alu_wb",   mk(2'b01, 3'b011, 3'b000, 3'b000, 1'b0, 8'hA5, 3'b011, 1'b0));
        issue(8'h9E, w0);
        expect_idle_after(3, "alu_idle");

        // CLR then MOV R1,R0 back-to-back
        push("clr",        mk(2'b00, 3'b000, 3'b000, 3'b000, 1'b0, 8'hA5, 3'b011, 1'b0));
        push("mov_r1_r0",  mk(2'b01, 3'b000, 3'b000, 3'b001, 1'b0, 8'hA5, 3'b011, 1'b0));
        issue(8'hC0, w0);
        issue(8'h08, w1);
        chk("b2b_accept_wait", 32'(w1), 32'd1);
        expect_idle_after(1, "b2b_idle");

        // Reset pulsed during ALU_WAIT aborts the writeback
        push("abort_read", mk(2'b11, 3'b000, 3'b000, 3'b010, 1'b0, 8'hA5, 3'b101, 1'b0));
        push("abort_wait", mk(2'b10, 3'b000, 3'b000, 3'b000, 1'b0, 8'hA5, 3'b101, 1'b0));
        issue(8'hAA, w0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_outputs", 32'(actual()), 32'(rst_v));
        chk("abort_busy",    32'(busy), 32'd0);
        chk("abort_err",     32'(err),  32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_write", 32'(enab), 32'(2'b10));
        end

        // Illegal SYS opcode 0xFF
`ifdef RFSEQ_ILLEGAL_TRAP_EN
        mon_en = 1'b0;
        issue(8'hFF, w0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("trap_err",   32'(err),      32'd1);
            chk("trap_ready", 32'(ir_ready), 32'd0);
            chk("trap_busy",  32'(busy),     32'd1);
            chk("trap_enab",  32'(enab),     32'(2'b10));
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("trap_reset_err",   32'(err),      32'd0);
        chk("trap_reset_ready", 32'(ir_ready), 32'd1);
`else
        issue(8'hFF, w0);
        @(negedge clk);
        chk("illegal_nop_busy",  32'(busy),     32'd0);
        chk("illegal_nop_ready", 32'(ir_ready), 32'd1);
        chk("illegal_nop_err",   32'(err),      32'd0);
        chk("illegal_nop_enab",  32'(enab),     32'(2'b10));
`endif

        // MVI R7 with no immediate: aborts after 8 waiting cycles
        for (int i = 0; i < 8; i++) push("timeout_imm_wait", imm_v);
        issue(8'h78, w0);
        expect_idle_after(8, "timeout_idle");
        chk("timeout_err", 32'(err), 32'd1);
        repeat (2) begin
            @(negedge clk);
            chk("timeout_no_write", 32'(enab), 32'(2'b10));
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
